// File: rtl/div_seq_pkg.sv
// Shared types and sizing for the iterative divide sequencer.
// Exposes FSM state encodings and default operand width.
package div_seq_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// result returned as {remainder, quotient} and held while start_i stays high.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic [1:0]            state_o
);

    // Handshake: start_i is a level held by EX until it has consumed the
    // result; ready_o marks result_o valid and stays high while start_i is
    // high; dropping start_i in END releases the block back to FREE.

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);

    div_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*DATA_W:0]      r_work;
    logic [DATA_W-1:0]      r_divisor;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [2*DATA_W-1:0]    r_result;
    logic                   r_ready;
    logic                   r_busy;

    logic                   w_neg1;
    logic                   w_neg2;
    logic [DATA_W-1:0]      w_dvd_abs;
    logic [DATA_W-1:0]      w_dvs_abs;
    logic [DATA_W:0]        w_diff;
    logic [DATA_W-1:0]      w_quot;
    logic [DATA_W-1:0]      w_rem;

    assign w_neg1    = signed_div_i & opdata1_i[DATA_W-1];
    assign w_neg2    = signed_div_i & opdata2_i[DATA_W-1];
    assign w_dvd_abs = w_neg1 ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    assign w_dvs_abs = w_neg2 ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

    // Trial subtraction of the divisor from {partial remainder, next dividend bit}.
    assign w_diff = r_work[2*DATA_W:DATA_W] - {1'b0, r_divisor};

    assign w_quot = r_neg_q ? (~r_work[DATA_W-1:0] + DATA_W'(1)) : r_work[DATA_W-1:0];
    assign w_rem  = r_neg_r ? (~r_work[2*DATA_W:DATA_W+1] + DATA_W'(1))
                            : r_work[2*DATA_W:DATA_W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                DIV_FREE: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                    if (start_i && !annul_i) begin
                        r_busy <= 1'b1;
                        if (opdata2_i == '0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state   <= DIV_ON;
                            r_divisor <= w_dvs_abs;
                            r_neg_q   <= w_neg1 ^ w_neg2;
                            r_neg_r   <= w_neg1;
                            r_work    <= {{DATA_W{1'b0}}, w_dvd_abs, 1'b0};
                            r_cnt     <= '0;
                        end
                    end
                end
                DIV_BYZERO: begin
                    r_busy <= 1'b0;
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_state  <= DIV_END;
                        r_result <= '0;
                        r_ready  <= 1'b1;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                        r_busy  <= 1'b0;
                        r_work  <= '0;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST_STEP) begin
                        r_state  <= DIV_END;
                        r_busy   <= 1'b0;
                        r_result <= {w_rem, w_quot};
                        r_ready  <= 1'b1;
                    end else begin
                        if (w_diff[DATA_W]) begin
                            r_work <= {r_work[2*DATA_W-1:0], 1'b0};
                        end else begin
                            r_work <= {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        r_state  <= DIV_FREE;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state <= DIV_FREE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = r_busy;
    assign state_o  = r_state;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// compared against a plain-arithmetic division model.
module tb_div_seq;
    import div_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;
    logic [1:0]  state;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [63:0] exp_q[$];

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    // Truncating division: quotient rounds toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'h0, a}) / longint'({32'h0, b});
            r = longint'({32'h0, a}) % longint'({32'h0, b});
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          lat;
        int          busy_n;
        int          exp_lat;
        bit          done;
        logic [63:0] exp;
        logic [63:0] got;
        exp_q.push_back(ref_div(sgn, a, b));
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        @(posedge clk); #1;
        busy_n = busy ? 1 : 0;
        lat = 0;
        done = 1'b0;
        op1 = $urandom;
        op2 = $urandom;
        for (int n = 1; n <= 60 && !done; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                done = 1'b1;
                lat  = n;
            end else if (busy) begin
                busy_n++;
            end
        end
        exp = exp_q.pop_front();
        total_cnt++;
        if (!done) begin
            $display("FAIL %s timeout: ready=%b expected ready=1 within 60 cycles", tag, ready);
            @(negedge clk); start = 1'b0;
            @(posedge clk); #1;
            return;
        end
        pass_cnt++;
        got = result;
        total_cnt++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_n !== exp_lat) $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_n, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (got !== exp) $display("FAIL %s result: got %h expected %h", tag, got, exp);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
        end
        total_cnt++;
        if (ready !== 1'b1 || result !== exp)
            $display("FAIL %s hold_end: got ready=%b result=%h expected ready=1 result=%h", tag, ready, result, exp);
        else pass_cnt++;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (ready !== 1'b0 || result !== 64'd0 || busy !== 1'b0)
            $display("FAIL %s release: got ready=%b busy=%b result=%h expected 0/0/0", tag, ready, busy, result);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (result !== 64'd0) $display("FAIL reset_result: got %h expected 0", result);
        else pass_cnt++;
        total_cnt++;
        if (ready !== 1'b0 || busy !== 1'b0) $display("FAIL reset_flags: got ready=%b busy=%b expected 0/0", ready, busy);
        else pass_cnt++;
        total_cnt++;
        if (state !== DIV_FREE) $display("FAIL reset_state: got %0d expected %0d", state, DIV_FREE);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(1'b0, 32'd7, 32'd2, "divu_7_2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        run_op(1'b0, 32'd3, 32'hFFFF_FFFF, "divu_small_big");
    endtask

    task automatic test_div_by_zero();
        run_op(1'b0, 32'd123, 32'd0, "divu_by_zero");
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, "div_by_zero");
    endtask

    task automatic test_annul();
        bit saw_ready = 1'b0;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'hDEAD_BEEF; op2 = 32'd3; start = 1'b1; annul = 1'b0;
        @(posedge clk);
        for (int s = 1; s <= 10; s++) begin
            @(posedge clk); #1;
            if (ready) saw_ready = 1'b1;
        end
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1;
        if (ready) saw_ready = 1'b1;
        total_cnt++;
        if (state !== DIV_FREE || busy !== 1'b0)
            $display("FAIL annul_free: got state=%0d busy=%b expected %0d/0", state, busy, DIV_FREE);
        else pass_cnt++;
        total_cnt++;
        if (saw_ready) $display("FAIL annul_ready: got ready=1 expected ready=0 throughout");
        else pass_cnt++;
        annul = 1'b0;
        run_op(1'b0, 32'd100, 32'd7, "after_annul");
    endtask

    task automatic test_annul_free();
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (state !== DIV_FREE || busy !== 1'b0)
            $display("FAIL annul_blocks_accept: got state=%0d busy=%b expected %0d/0", state, busy, DIV_FREE);
        else pass_cnt++;
        start = 1'b0; annul = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        signed_div = 1'b1; op1 = 32'h1234_5678; op2 = 32'hFFFF_FF00; start = 1'b1; annul = 1'b0;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0 || state !== DIV_FREE)
            $display("FAIL reset_mid: got ready=%b busy=%b result=%h state=%0d expected 0/0/0/%0d",
                     ready, busy, result, state, DIV_FREE);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, "after_reset");
    endtask

    task automatic test_random();
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0 - 32'($urandom_range(1, 9));
                default: b = a >> $urandom_range(1, 20);
            endcase
            run_op(sgn, a, b, $sformatf("rand_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_annul();
        test_annul_free();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
